// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the writeback entry layout and
// the opcode constants used by the ALU and the decoder.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_ENC_W = 2;
  localparam int CNT_W     = 2;

  typedef struct packed {
    logic [REG_ENC_W-1:0] enc;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5
  } alu_op_e;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO that buffers EX results ahead of register-file writeback.
// A push while full and a pop while empty are ignored.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = $bits(wb_entry_t)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_ok_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/reg_writeback.sv
// WB stage: buffers EX results, drives the register-file write port and
// tracks pending writes per register to stall decode on RAW hazards.
// Optional bypass of the retiring value to decode: define WB_FORWARD_EN.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int REG_ENC_W = cpu_pkg::REG_ENC_W,
  parameter int CNT_W     = cpu_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_ENC_W-1:0] issue_wb_enc,
  input  logic                 rd_use_0,
  input  logic [REG_ENC_W-1:0] rd_enc_0,
  input  logic                 rd_use_1,
  input  logic [REG_ENC_W-1:0] rd_enc_1,
  output logic                 hazard_stall,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [REG_ENC_W-1:0] ex_wb_enc,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 wb_hold,
`ifdef WB_FORWARD_EN
  output logic                 fwd_hit_0,
  output logic [DATA_W-1:0]    fwd_data_0,
  output logic                 fwd_hit_1,
  output logic [DATA_W-1:0]    fwd_data_1,
`endif
  output logic                 we,
  output logic [REG_ENC_W-1:0] r_write_enc,
  output logic [DATA_W-1:0]    wdata
);

  localparam int              NREG     = 2 ** REG_ENC_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;
  logic [REG_ENC_W-1:0] head_enc_s;
  logic [DATA_W-1:0]    head_data_s;
  logic                 hit0_s;
  logic                 hit1_s;
  logic                 issue_accept_s;
  logic [CNT_W-1:0]     cnt_r [NREG];
  logic [NREG-1:0]      inc_s;
  logic [NREG-1:0]      dec_s;

  wb_fifo #(.WIDTH(REG_ENC_W + DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ex_valid),
    .pop   (pop_s),
    .din   ({ex_wb_enc, ex_result}),
    .full  (full_s),
    .empty (empty_s),
    .head  ({head_enc_s, head_data_s})
  );

  assign ex_ready = !full_s;
  assign pop_s    = !wb_hold && !empty_s;

`ifdef WB_FORWARD_EN
  // A source is bypassed only when the retiring write is its last pending one.
  assign fwd_hit_0  = rd_use_0 && we && (r_write_enc == rd_enc_0) && (cnt_r[rd_enc_0] == CNT_ONE);
  assign fwd_hit_1  = rd_use_1 && we && (r_write_enc == rd_enc_1) && (cnt_r[rd_enc_1] == CNT_ONE);
  assign fwd_data_0 = wdata;
  assign fwd_data_1 = wdata;
  assign hit0_s     = fwd_hit_0;
  assign hit1_s     = fwd_hit_1;
`else
  assign hit0_s = 1'b0;
  assign hit1_s = 1'b0;
`endif

  assign hazard_stall = (rd_use_0 && (cnt_r[rd_enc_0] != CNT_ZERO) && !hit0_s) ||
                        (rd_use_1 && (cnt_r[rd_enc_1] != CNT_ZERO) && !hit1_s) ||
                        (issue_valid && (cnt_r[issue_wb_enc] == CNT_MAX));
  assign issue_accept_s = issue_valid && !hazard_stall;

  // Per-register increment/decrement requests for this cycle.
  always_comb begin
    inc_s = {NREG{1'b0}};
    dec_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      inc_s[i] = issue_accept_s && (issue_wb_enc == REG_ENC_W'(i));
      dec_s[i] = we && (r_write_enc == REG_ENC_W'(i));
    end
  end

  // Pending-write scoreboard; a decrement at zero is held at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10: cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01: begin
            if (cnt_r[i] != CNT_ZERO) cnt_r[i] <= cnt_r[i] - CNT_ONE;
            else                      cnt_r[i] <= CNT_ZERO;
          end
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Register-file write port, loaded from the FIFO head on each pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      we          <= 1'b0;
      r_write_enc <= {REG_ENC_W{1'b0}};
      wdata       <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      we          <= 1'b1;
      r_write_enc <= head_enc_s;
      wdata       <= head_data_s;
    end else begin
      we          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus a random
// run, all compared against a queue/array reference model of the WB stage.
module tb_reg_writeback;

  localparam int DW   = 32;
  localparam int EW   = 2;
  localparam int NREG = 4;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          reset, issue_valid, rd_use_0, rd_use_1, ex_valid, wb_hold;
  logic [EW-1:0] issue_wb_enc, rd_enc_0, rd_enc_1, ex_wb_enc;
  logic [DW-1:0] ex_result;
  wire           hazard_stall, ex_ready, we;
  wire  [EW-1:0] r_write_enc;
  wire  [DW-1:0] wdata;
`ifdef WB_FORWARD_EN
  wire           fwd_hit_0, fwd_hit_1;
  wire  [DW-1:0] fwd_data_0, fwd_data_1;
`endif

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wb_enc(issue_wb_enc),
    .rd_use_0(rd_use_0), .rd_enc_0(rd_enc_0), .rd_use_1(rd_use_1), .rd_enc_1(rd_enc_1),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wb_enc(ex_wb_enc), .ex_result(ex_result), .wb_hold(wb_hold),
`ifdef WB_FORWARD_EN
    .fwd_hit_0(fwd_hit_0), .fwd_data_0(fwd_data_0), .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
`endif
    .we(we), .r_write_enc(r_write_enc), .wdata(wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered results, pending-write counts, write port.
  typedef struct {
    logic [EW-1:0] enc;
    logic [DW-1:0] data;
  } ent_t;
  ent_t          mq[$];
  int            mcnt[NREG];
  bit            m_we   = 1'b0;
  int            m_enc  = 0;
  logic [DW-1:0] m_data = '0;

  function automatic bit m_fwd(bit use_, int enc);
`ifdef WB_FORWARD_EN
    return use_ && m_we && (m_enc == enc) && (mcnt[enc] == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_stall();
    return (rd_use_0 && mcnt[rd_enc_0] != 0 && !m_fwd(rd_use_0, int'(rd_enc_0))) ||
           (rd_use_1 && mcnt[rd_enc_1] != 0 && !m_fwd(rd_use_1, int'(rd_enc_1))) ||
           (issue_valid && mcnt[issue_wb_enc] == CMAX);
  endfunction

  // One rising edge; the model applies the same edge from pre-edge inputs.
  task automatic tick();
    bit   stall, acc, pop;
    ent_t e;
    stall = m_stall();
    acc   = ex_valid && (mq.size() < 2);
    pop   = !wb_hold && (mq.size() > 0);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NREG; i++) mcnt[i] = 0;
      m_we = 1'b0; m_enc = 0; m_data = '0;
    end else begin
      if (m_we) begin
        n_checks++;
        if (mcnt[m_enc] == 0) begin
          n_fail++;
          $display("FAIL dec_at_zero: reg %0d retired with pending count 0 (required >0)", m_enc);
        end else mcnt[m_enc]--;
      end
      if (issue_valid && !stall) mcnt[issue_wb_enc]++;
      if (pop) begin
        e = mq.pop_front();
        m_we = 1'b1; m_enc = int'(e.enc); m_data = e.data;
      end else m_we = 1'b0;
      if (acc) begin
        e.enc = ex_wb_enc; e.data = ex_result;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wb_enc = '0; rd_use_0 = 1'b0; rd_enc_0 = '0;
    rd_use_1 = 1'b0; rd_enc_1 = '0; ex_valid = 1'b0; ex_wb_enc = '0;
    ex_result = '0; wb_hold = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", we); end
    n_checks++; if (r_write_enc !== 2'd0) begin n_fail++; $display("FAIL reset_enc got=%0d exp=0", r_write_enc); end
    n_checks++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", ex_ready); end
    rd_use_0 = 1'b1; rd_enc_0 = 2'd1; rd_use_1 = 1'b1; rd_enc_1 = 2'd3; #1;
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", hazard_stall); end
    idle();
  endtask

  task automatic test_writeback_and_raw();
    idle(); issue_valid = 1'b1; issue_wb_enc = 2'd1; #1;
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL issue_stall got=%0b exp=0", hazard_stall); end
    tick(); issue_valid = 1'b0; rd_use_0 = 1'b1; rd_enc_0 = 2'd1; #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_pending got=%0b exp=1", hazard_stall); end
    ex_valid = 1'b1; ex_wb_enc = 2'd1; ex_result = 32'h5; tick(); ex_valid = 1'b0;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL wb_latency_early got=%0b exp=0", we); end
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_buffered got=%0b exp=1", hazard_stall); end
    tick();
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL wb_we got=%0b exp=1", we); end
    n_checks++; if (r_write_enc !== 2'd1) begin n_fail++; $display("FAIL wb_enc got=%0d exp=1", r_write_enc); end
    n_checks++; if (wdata !== 32'h5) begin n_fail++; $display("FAIL wb_wdata got=%h exp=5", wdata); end
`ifdef WB_FORWARD_EN
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall got=%0b exp=0", hazard_stall); end
    n_checks++; if (fwd_hit_0 !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got=%0b exp=1", fwd_hit_0); end
    n_checks++; if (fwd_data_0 !== 32'h5) begin n_fail++; $display("FAIL fwd_data got=%h exp=5", fwd_data_0); end
`else
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_writing got=%0b exp=1", hazard_stall); end
`endif
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL wb_we_drop got=%0b exp=0", we); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got=%0b exp=0", hazard_stall); end
    idle();
  endtask

  task automatic test_hold_backpressure();
    idle(); issue_valid = 1'b1; issue_wb_enc = 2'd2; tick(); tick(); issue_valid = 1'b0;
    wb_hold = 1'b1; ex_valid = 1'b1; ex_wb_enc = 2'd2; ex_result = 32'hA; tick();
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready1 got=%0b exp=1", ex_ready); end
    ex_result = 32'hB; tick(); ex_valid = 1'b0;
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL hold_full got=%0b exp=0", ex_ready); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL hold_we got=%0b exp=0", we); end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL hold_we2 got=%0b exp=0", we); end
    wb_hold = 1'b0; tick();
    n_checks++; if (we !== 1'b1 || wdata !== 32'hA) begin n_fail++; $display("FAIL drain_first got we=%0b wdata=%h exp we=1 wdata=a", we, wdata); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got=%0b exp=1", ex_ready); end
    tick();
    n_checks++; if (we !== 1'b1 || wdata !== 32'hB) begin n_fail++; $display("FAIL drain_second got we=%0b wdata=%h exp we=1 wdata=b", we, wdata); end
    tick(); rd_use_0 = 1'b1; rd_enc_0 = 2'd2; #1;
    n_checks++; if (we !== 1'b0 || hazard_stall !== 1'b0) begin n_fail++; $display("FAIL drain_done got we=%0b stall=%0b exp 0 0", we, hazard_stall); end
    idle();
  endtask

  task automatic test_same_cycle_inc_dec();
    idle(); issue_valid = 1'b1; issue_wb_enc = 2'd0; tick(); issue_valid = 1'b0;
    ex_valid = 1'b1; ex_wb_enc = 2'd0; ex_result = 32'hC; tick(); ex_valid = 1'b0; tick();
    n_checks++; if (we !== 1'b1 || r_write_enc !== 2'd0) begin n_fail++; $display("FAIL r0_retire got we=%0b enc=%0d exp 1 0", we, r_write_enc); end
    issue_valid = 1'b1; issue_wb_enc = 2'd0; #1;
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL r0_issue_stall got=%0b exp=0", hazard_stall); end
    tick(); issue_valid = 1'b0; rd_use_0 = 1'b1; rd_enc_0 = 2'd0; #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL r0_net_unchanged got=%0b exp=1", hazard_stall); end
    ex_valid = 1'b1; ex_result = 32'hD; tick(); ex_valid = 1'b0; tick(); tick();
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL r0_cleared got=%0b exp=0", hazard_stall); end
    idle();
  endtask

  task automatic test_saturation();
    idle(); issue_valid = 1'b1; issue_wb_enc = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sat_issue%0d got=%0b exp=0", k, hazard_stall); end
      tick();
    end
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sat_fourth got=%0b exp=1", hazard_stall); end
    tick(); #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sat_hold got=%0b exp=1", hazard_stall); end
    issue_valid = 1'b0; rd_use_0 = 1'b1; rd_enc_0 = 2'd2;
    ex_valid = 1'b1; ex_wb_enc = 2'd2;
    for (int k = 0; k < 3; k++) begin
      ex_result = 32'h100 + k; tick();
      n_checks++; if (we !== (k > 0)) begin n_fail++; $display("FAIL sat_we%0d got=%0b exp=%0b", k, we, k > 0); end
    end
    ex_valid = 1'b0; tick();
    n_checks++; if (we !== 1'b1 || wdata !== 32'h102) begin n_fail++; $display("FAIL sat_last got we=%0b wdata=%h exp 1 102", we, wdata); end
`ifdef WB_FORWARD_EN
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sat_fwd got=%0b exp=0", hazard_stall); end
`else
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL sat_last_pending got=%0b exp=1", hazard_stall); end
`endif
    tick();
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL sat_released got=%0b exp=0", hazard_stall); end
    idle();
  endtask

  task automatic test_reset_midflight();
    idle(); wb_hold = 1'b1; issue_valid = 1'b1; issue_wb_enc = 2'd3; tick(); tick(); issue_valid = 1'b0;
    ex_valid = 1'b1; ex_wb_enc = 2'd3; ex_result = 32'hE; tick(); ex_result = 32'hF; tick(); ex_valid = 1'b0;
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got=%0b exp=0", ex_ready); end
    reset = 1'b1; wb_hold = 1'b0; tick(); reset = 1'b0;
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%0b exp=1", ex_ready); end
    n_checks++; if (we !== 1'b0 || wdata !== 32'h0) begin n_fail++; $display("FAIL mid_port got we=%0b wdata=%h exp 0 0", we, wdata); end
    for (int r = 0; r < NREG; r++) begin
      rd_use_0 = 1'b1; rd_enc_0 = EW'(r); #1;
      n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL mid_cnt%0d got stall=%0b exp=0", r, hazard_stall); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d got=%0b exp=0", k, we); end
    end
    idle();
  endtask

  task automatic test_random();
    logic [EW-1:0] iss_q[$];
    bit issue_acc, ex_acc;
    idle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wb_hold      = ($urandom_range(0, 3) == 0);
      rd_use_0     = 1'($urandom_range(0, 1)); rd_enc_0 = EW'($urandom_range(0, 3));
      rd_use_1     = 1'($urandom_range(0, 1)); rd_enc_1 = EW'($urandom_range(0, 3));
      issue_valid  = 1'($urandom_range(0, 1)); issue_wb_enc = EW'($urandom_range(0, 3));
      if (iss_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        ex_valid = 1'b1; ex_wb_enc = iss_q[0]; ex_result = $urandom;
      end else ex_valid = 1'b0;
      #1;
      n_checks++; if (hazard_stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, hazard_stall, m_stall()); end
      n_checks++; if (ex_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, ex_ready, mq.size() < 2); end
`ifdef WB_FORWARD_EN
      n_checks++; if (fwd_hit_0 !== m_fwd(rd_use_0, int'(rd_enc_0))) begin n_fail++; $display("FAIL rnd_fwd0 cyc=%0d got=%0b", cyc, fwd_hit_0); end
`endif
      issue_acc = issue_valid && !m_stall();
      ex_acc    = ex_valid && (mq.size() < 2);
      tick();
      if (issue_acc) iss_q.push_back(issue_wb_enc);
      if (ex_acc) void'(iss_q.pop_front());
      n_checks++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", cyc, we, m_we); end
      if (m_we) begin
        n_checks++;
        if (r_write_enc !== EW'(m_enc) || wdata !== m_data) begin
          n_fail++; $display("FAIL rnd_write cyc=%0d got enc=%0d data=%h exp enc=%0d data=%h", cyc, r_write_enc, wdata, m_enc, m_data);
        end
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_writeback_and_raw();
    test_hold_backpressure();
    test_same_cycle_inc_dec();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
